// File: rtl/timer_run.sv
// timer_run: countdown engine for the timer page.
// Counts a MIN/SEC preset down at a 1 s tick, then raises ALARM for a while.
module timer_run #(
  parameter int TICK_DIV  = 1000,
  parameter int ALARM_SEC = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] MIN_A,
  input  logic [6:0] SEC_A,
  input  logic       START,
  input  logic       CLR,
  output logic [6:0] MIN_R,
  output logic [6:0] SEC_R,
  output logic       RUN,
  output logic       ALARM
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int AW = $clog2(ALARM_SEC + 1);
  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);
  localparam logic [AW-1:0] ALM_TOP = AW'(ALARM_SEC);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_ALARM
  } state_t;

  state_t        state_q, state_d;
  logic          start_last_q, start_last_d;
  logic          start_en_q, start_en_d;
  logic          clr_last_q, clr_last_d;
  logic          clr_en_q, clr_en_d;
  logic [6:0]    min_q, min_d;
  logic [6:0]    sec_q, sec_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic          run_q, run_d;
  logic          alarm_q, alarm_d;

  logic [6:0]    sec_clamp;
  logic          preset_zero;
  logic          tick;
  logic [PW-1:0] pre_inc;
  logic [AW-1:0] acnt_inc;
  logic [6:0]    min_dec;
  logic [6:0]    sec_dec;
  logic          dec_zero;

  assign sec_clamp   = (SEC_A > 7'd59) ? 7'd59 : SEC_A;
  assign preset_zero = (MIN_A == 7'd0) && (sec_clamp == 7'd0);
  assign tick        = (pre_q == PRE_TOP);
  assign pre_inc     = tick ? '0 : pre_q + 1'b1;
  assign acnt_inc    = acnt_q + 1'b1;
  assign dec_zero    = (min_dec == 7'd0) && (sec_dec == 7'd0);

  // One-second decrement of the remaining mm:ss with minute borrow
  always_comb begin
    min_dec = min_q;
    sec_dec = sec_q - 7'd1;
    if (sec_q == 7'd0) begin
      min_dec = min_q - 7'd1;
      sec_dec = 7'd59;
    end
  end

  // Rising-edge detect on the two buttons
  always_comb begin
    start_last_d = START;
    clr_last_d   = CLR;
    start_en_d   = START & ~start_last_q;
    clr_en_d     = CLR & ~clr_last_q;
  end

  // Next state, counters and registered status outputs
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    pre_d   = pre_q;
    acnt_d  = acnt_q;
    if (clr_en_q) begin
      state_d = S_IDLE;
      pre_d   = '0;
      acnt_d  = '0;
      if (state_q == S_IDLE) begin
        min_d = MIN_A;
        sec_d = sec_clamp;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          min_d = MIN_A;
          sec_d = sec_clamp;
          pre_d = '0;
          if (start_en_q && !preset_zero) state_d = S_RUN;
        end
        S_RUN: begin
          pre_d = pre_inc;
          if (tick) begin
            min_d = min_dec;
            sec_d = sec_dec;
          end
          if (tick && dec_zero) begin
            state_d = S_ALARM;
            pre_d   = '0;
            acnt_d  = '0;
          end else if (start_en_q) begin
            state_d = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (start_en_q) state_d = S_RUN;
        end
        S_ALARM: begin
          min_d = 7'd0;
          sec_d = 7'd0;
          pre_d = pre_inc;
          if (tick) acnt_d = acnt_inc;
          if (start_en_q || (tick && acnt_inc == ALM_TOP)) begin
            state_d = S_IDLE;
            pre_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    run_d   = (state_d == S_RUN);
    alarm_d = (state_d == S_ALARM);
  end

  // State and datapath registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      start_last_q <= 1'b0;
      start_en_q   <= 1'b0;
      clr_last_q   <= 1'b0;
      clr_en_q     <= 1'b0;
      min_q        <= 7'd0;
      sec_q        <= 7'd0;
      pre_q        <= '0;
      acnt_q       <= '0;
      run_q        <= 1'b0;
      alarm_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_last_q <= start_last_d;
      start_en_q   <= start_en_d;
      clr_last_q   <= clr_last_d;
      clr_en_q     <= clr_en_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      pre_q        <= pre_d;
      acnt_q       <= acnt_d;
      run_q        <= run_d;
      alarm_q      <= alarm_d;
    end
  end

  assign MIN_R = min_q;
  assign SEC_R = sec_q;
  assign RUN   = run_q;
  assign ALARM = alarm_q;

endmodule

// File: tb/tb_timer_run.sv
// tb_timer_run: scenario tasks for timer_run, checked against a
// time-based reference model (remaining = total - run_cycles / TICK_DIV).
module tb_timer_run;

  localparam int TD = 4;
  localparam int AS = 2;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_ALM   = 3;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [6:0] MIN_A = 7'd0;
  logic [6:0] SEC_A = 7'd0;
  logic       START = 1'b0;
  logic       CLR = 1'b0;
  logic [6:0] MIN_R;
  logic [6:0] SEC_R;
  logic       RUN;
  logic       ALARM;

  int n_chk = 0;
  int n_pass = 0;
  int run_seen = 0;

  int m_mode, m_rem, m_total, m_cyc, m_acyc;
  bit m_slast, m_clast, m_sen, m_cen;

  timer_run #(.TICK_DIV(TD), .ALARM_SEC(AS)) dut (
    .CLK(CLK), .RESET(RESET), .MIN_A(MIN_A), .SEC_A(SEC_A),
    .START(START), .CLR(CLR), .MIN_R(MIN_R), .SEC_R(SEC_R),
    .RUN(RUN), .ALARM(ALARM)
  );

  always #5 CLK = ~CLK;

  function automatic int preset_secs();
    int s;
    s = (SEC_A > 7'd59) ? 59 : int'(SEC_A);
    return int'(MIN_A) * 60 + s;
  endfunction

  function automatic logic [15:0] exp_vec();
    return {7'(m_rem / 60), 7'(m_rem % 60),
            1'(m_mode == M_RUN), 1'(m_mode == M_ALM)};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {MIN_R, SEC_R, RUN, ALARM};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_rem = 0; m_total = 0; m_cyc = 0; m_acyc = 0;
    m_slast = 0; m_clast = 0; m_sen = 0; m_cen = 0;
  endtask

  // model advance for one clock edge, using the inputs present at the edge
  task automatic model_edge();
    int p;
    bit se, ce;
    p = preset_secs();
    se = m_sen;
    ce = m_cen;
    m_sen = START && !m_slast;
    m_cen = CLR && !m_clast;
    m_slast = START;
    m_clast = CLR;
    case (m_mode)
      M_IDLE: begin
        m_rem = p;
        if (!ce && se && p != 0) begin
          m_mode = M_RUN; m_total = p; m_cyc = 0;
        end
      end
      M_RUN: begin
        if (ce) m_mode = M_IDLE;
        else begin
          m_cyc++;
          m_rem = m_total - m_cyc / TD;
          if (m_rem == 0) begin m_mode = M_ALM; m_acyc = 0; end
          else if (se) m_mode = M_PAUSE;
        end
      end
      M_PAUSE: begin
        if (ce) m_mode = M_IDLE;
        else if (se) m_mode = M_RUN;
      end
      default: begin
        if (ce || se) m_mode = M_IDLE;
        else begin
          m_acyc++;
          if (m_acyc == AS * TD) m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic cyc();
    @(posedge CLK);
    if (!RESET) model_edge();
    #1;
    if (RUN) run_seen++;
  endtask

  task automatic test_reset();
    RESET = 1'b1; MIN_A = 7'd0; SEC_A = 7'd3;
    model_reset();
    #2;
    n_chk++;
    if (dut_vec() !== 16'h0) $display("FAIL reset_vals: got %h expected 0000", dut_vec());
    else n_pass++;
    cyc(); cyc();
    RESET = 1'b0;
    #1;
    n_chk++;
    if (dut_vec() !== 16'h0) $display("FAIL reset_release: got %h expected 0000", dut_vec());
    else n_pass++;
    cyc();
    n_chk++;
    if ({MIN_R, SEC_R} !== {7'd0, 7'd3})
      $display("FAIL reset_preset: got %0d:%0d expected 0:3", MIN_R, SEC_R);
    else n_pass++;
  endtask

  task automatic test_basic();
    int n;
    MIN_A = 7'd0; SEC_A = 7'd3;
    cyc();
    START = 1'b1;
    cyc();
    n_chk++;
    if (RUN !== 1'b0) $display("FAIL basic_run_early: got %b expected 0", RUN);
    else n_pass++;
    cyc();
    START = 1'b0;
    n_chk++;
    if (RUN !== 1'b1) $display("FAIL basic_run_latency: got %b expected 1", RUN);
    else n_pass++;
    n = 0;
    while (!ALARM && n < 40) begin
      cyc(); n++;
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL basic_count: got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (n !== 12) $display("FAIL basic_run_len: got %0d expected 12", n);
    else n_pass++;
    n = 0;
    while (ALARM && n < 40) begin
      cyc(); n++;
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL basic_alarm: got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (n !== 8) $display("FAIL basic_alarm_len: got %0d expected 8", n);
    else n_pass++;
    cyc();
    n_chk++;
    if ({MIN_R, SEC_R, RUN} !== {7'd0, 7'd3, 1'b0})
      $display("FAIL basic_reload: got %0d:%0d run=%b expected 0:3 run=0", MIN_R, SEC_R, RUN);
    else n_pass++;
  endtask

  task automatic test_min_wrap();
    int n;
    MIN_A = 7'd1; SEC_A = 7'd0;
    cyc();
    START = 1'b1; cyc(); cyc(); START = 1'b0;
    for (int i = 0; i < TD; i++) cyc();
    n_chk++;
    if ({MIN_R, SEC_R} !== {7'd0, 7'd59})
      $display("FAIL wrap_first_tick: got %0d:%0d expected 0:59", MIN_R, SEC_R);
    else n_pass++;
    n = 0;
    while (!ALARM && n < 300) begin
      cyc(); n++;
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL wrap_count: got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (!ALARM) $display("FAIL wrap_alarm: got timeout expected ALARM after %0d cycles", n);
    else n_pass++;
    n = 0;
    while (ALARM && n < 40) begin cyc(); n++; end
  endtask

  task automatic test_pause();
    int n;
    MIN_A = 7'd0; SEC_A = 7'd5;
    cyc();
    run_seen = 0;
    START = 1'b1; cyc(); cyc(); START = 1'b0;
    for (int i = 0; i < 6; i++) cyc();
    START = 1'b1; cyc(); cyc(); START = 1'b0;
    n_chk++;
    if (RUN !== 1'b0) $display("FAIL pause_enter: got RUN=%b expected 0", RUN);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL pause_freeze: got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
    end
    START = 1'b1; cyc(); cyc(); START = 1'b0;
    n = 0;
    while (!ALARM && n < 100) begin
      cyc(); n++;
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL pause_resume: got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
    end
    n_chk++;
    if (run_seen !== 5 * TD)
      $display("FAIL pause_residency: got %0d expected %0d", run_seen, 5 * TD);
    else n_pass++;
    n = 0;
    while (ALARM && n < 40) begin cyc(); n++; end
  endtask

  task automatic test_clamp();
    MIN_A = 7'd2; SEC_A = 7'd60;
    cyc();
    n_chk++;
    if ({MIN_R, SEC_R} !== {7'd2, 7'd59})
      $display("FAIL clamp_sec: got %0d:%0d expected 2:59", MIN_R, SEC_R);
    else n_pass++;
    MIN_A = 7'd0; SEC_A = 7'd0;
    START = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL zero_start: got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
    end
    START = 1'b0;
    n_chk++;
    if ({RUN, MIN_R, SEC_R} !== 15'd0)
      $display("FAIL zero_idle: got run=%b %0d:%0d expected run=0 0:0", RUN, MIN_R, SEC_R);
    else n_pass++;
  endtask

  task automatic test_clr_start();
    int toggles;
    logic prev;
    MIN_A = 7'd0; SEC_A = 7'd9;
    cyc();
    START = 1'b1; cyc(); cyc(); START = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    START = 1'b1; CLR = 1'b1;
    cyc(); cyc();
    START = 1'b0; CLR = 1'b0;
    cyc();
    n_chk++;
    if ({RUN, MIN_R, SEC_R} !== {1'b0, 7'd0, 7'd9})
      $display("FAIL clr_beats_start: got run=%b %0d:%0d expected run=0 0:9", RUN, MIN_R, SEC_R);
    else n_pass++;
    SEC_A = 7'd30;
    cyc();
    START = 1'b1;
    toggles = 0;
    prev = RUN;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (RUN !== prev) toggles++;
      prev = RUN;
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL held_start: got %h expected %h", dut_vec(), exp_vec());
      else n_pass++;
    end
    START = 1'b0;
    n_chk++;
    if (toggles !== 1) $display("FAIL held_start_toggles: got %0d expected 1", toggles);
    else n_pass++;
    CLR = 1'b1; cyc(); CLR = 1'b0; cyc(); cyc();
    n_chk++;
    if ({RUN, SEC_R} !== {1'b0, 7'd30})
      $display("FAIL clr_run: got run=%b sec=%0d expected run=0 sec=30", RUN, SEC_R);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    MIN_A = 7'd0; SEC_A = 7'd2;
    cyc();
    START = 1'b1; cyc(); cyc(); START = 1'b0;
    cyc();
    RESET = 1'b1;
    #1;
    model_reset();
    n_chk++;
    if (dut_vec() !== 16'h0) $display("FAIL reset_mid: got %h expected 0000", dut_vec());
    else n_pass++;
    cyc();
    RESET = 1'b0;
    cyc();
    n_chk++;
    if (dut_vec() !== {7'd0, 7'd2, 1'b0, 1'b0})
      $display("FAIL reset_mid_track: got %h expected %h", dut_vec(), {7'd0, 7'd2, 2'b00});
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        MIN_A = 7'($urandom_range(0, 1));
        SEC_A = 7'($urandom_range(0, 60));
      end
      if ($urandom_range(0, 14) == 0) START = ~START;
      CLR = ($urandom_range(0, 199) == 0);
      cyc();
      n_chk++;
      if (dut_vec() !== exp_vec())
        $display("FAIL random_cyc%0d: got %h expected %h", i, dut_vec(), exp_vec());
      else n_pass++;
    end
    START = 1'b0; CLR = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_wrap();
    test_pause();
    test_clamp();
    test_clr_start();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/timer_run.md
# timer_run

Countdown engine for the timer page: consumes the minute/second preset produced by the timer-setting block (MIN_A/SEC_A) and counts it down to 00:00 at a 1 s tick derived from CLK. START toggles run/pause, CLR aborts, and ALARM is asserted for a fixed number of seconds on expiry. Outputs MIN_R/SEC_R drive the same display mux as the preset values.

## Interface

- TICK_DIV, 1000: CLK cycles per 1 s tick (CLK is 1 kHz); must be ≥2.
- ALARM_SEC, 5: ticks for which ALARM stays high after expiry; must be ≥1.

- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset. One clock domain; reset polarity and synchronicity are fixed.
- MIN_A  in  7  preset minutes, 0..59.
- SEC_A  in  7  preset seconds, 0..60. The setter can emit 60; this block clamps it.
- START  in  1  start/pause button, level, already debounced.
- CLR  in  1  clear button, level, already debounced.
- MIN_R  out  7  remaining minutes.
- SEC_R  out  7  remaining seconds.
- RUN  out  1  high in state RUN.
- ALARM  out  1  high in state ALARM.

## Operation

- Edge detect on START and CLR:
  - X_LAST <= X.
  - X_EN <= X & ~X_LAST.
  - Both registered; the FSM acts only on START_EN and CLR_EN.
- States: IDLE, RUN, PAUSE, ALARM. Encoding is free.
- IDLE:
  - Every cycle, MIN_R <= MIN_A and SEC_R <= (SEC_A > 59 ? 59 : SEC_A).
  - Prescaler is 0.
  - START_EN with a clamped preset of 00:00: stay in IDLE.
  - START_EN with a non-zero preset: go to RUN.
- RUN:
  - Prescaler counts 0..TICK_DIV-1 and wraps. Tick = (prescaler == TICK_DIV-1).
  - On a tick, if SEC_R ≠ 0: SEC_R - 1.
  - On a tick, if SEC_R = 0: SEC_R = 59 and MIN_R - 1.
  - If a tick produces 00:00: go to ALARM, clear the prescaler, clear the alarm counter.
  - START_EN: go to PAUSE.
- PAUSE:
  - MIN_R, SEC_R and the prescaler are held.
  - START_EN: go to RUN. The prescaler resumes from its held value.
- ALARM:
  - MIN_R and SEC_R stay at 00:00.
  - The prescaler runs.
  - The alarm counter increments per tick.
  - When the counter reaches ALARM_SEC: go to IDLE.
  - START_EN: go to IDLE.
- CLR_EN in any state: go to IDLE, prescaler = 0.
- Priorities and simultaneous events:
  - CLR_EN beats START_EN.
  - CLR_EN beats a tick: no decrement is applied.
  - Tick and START_EN in the same cycle of RUN: the decrement is applied and the state goes to PAUSE. If that decrement reaches 00:00, ALARM wins over PAUSE.
- Arithmetic:
  - All counters are unsigned.
  - MIN_R never underflows, because 00:00 exits RUN.
  - Prescaler width is clog2(TICK_DIV).
  - Alarm counter width is clog2(ALARM_SEC+1).

## Timing

- Reset values:
  - State = IDLE.
  - MIN_R = 0, SEC_R = 0.
  - RUN = 0, ALARM = 0.
  - Prescaler = 0, alarm counter = 0.
  - START_LAST, CLR_LAST, START_EN and CLR_EN all = 0.
- On the first clock after reset release, MIN_R/SEC_R follow the preset.
- Button latency: START or CLR first sampled high at edge k → X_EN high after edge k → state and RUN/ALARM change at edge k+1.
- A held button produces exactly one action.
- First decrement occurs TICK_DIV cycles after entering RUN from IDLE.
- RUN and ALARM are registered and change on the same edge as the state.
- With a full pause/resume, total RUN residency is exactly (MIN·60 + SEC)·TICK_DIV cycles before ALARM rises.
- RESET asserted mid-count: all outputs go to their reset values immediately (asynchronous), with no alarm.

## Test plan

Run all scenarios with TICK_DIV=4 and ALARM_SEC=2.

- Reset, then MIN_A=0 and SEC_A=3, then a START pulse → RUN=1 two edges later. SEC_R steps 3, 2, 1, 0 every 4 cycles. ALARM=1 on the edge SEC_R becomes 0, stays high 8 cycles, then IDLE with SEC_R=3.
- MIN_A=1 and SEC_A=0, then START → first tick gives 00:59. Counting continues down to 00:00, then ALARM.
- Start from 00:05. After 6 cycles in RUN, START → PAUSE and the outputs freeze for 20 cycles. START again → the next decrement arrives after the remaining 2 prescaler cycles.
- SEC_A=60 → SEC_R=59 in IDLE. Preset 00:00 plus START → remains IDLE with RUN=0.
- START and CLR rise on the same cycle during RUN → IDLE, MIN_R/SEC_R reload the preset, RUN=0. Holding START high for 50 cycles yields a single toggle only.
- RESET pulsed for 1 cycle mid-RUN at 00:02 → immediately MIN_R=0, SEC_R=0, RUN=0, ALARM=0. After release, the outputs track the preset.
